deserializer: RTL

Serial-to-parallel receiver, the far end of the `serializer` link. It watches a one-bit data line qualified by a frame strobe, which is the transmitter's `busy`. It reassembles each `DATA_WIDTH`-bit word LSB-first and presents it on a valid/ready parallel port. It flags truncated frames and words dropped because the consumer was stalled.

---
 rtl/serial_link_pkg.sv | 12 +
 rtl/deserializer_out_reg.sv | 46 ++++
 rtl/deserializer.sv | 101 ++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serializer/deserializer link: state encoding and counter sizing.
package serial_link_pkg;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_RECEIVE = 1'b1;

    // Bit-counter width for a given word width.
    function automatic int unsigned counter_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/deserializer_out_reg.sv
// Valid/ready holding register for received words; raises overrun when a word must be dropped.
module deserializer_out_reg
    import serial_link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_overrun
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;

    // A completing word replaces the held one only if the slot is empty or being consumed now.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_load) begin
                if (!r_valid || i_ready) begin
                    r_data  <= i_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: reassembles LSB-first words framed by frame_in.
module deserializer
    import serial_link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned COUNTER_SIZE = counter_width(DATA_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  frame_in,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  frame_error,
    output logic                  overrun
);

    logic                    r_state;
    logic                    w_state_n;
    logic [COUNTER_SIZE-1:0] r_count;
    logic [COUNTER_SIZE-1:0] w_count_n;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   w_shift_n;
    logic [DATA_WIDTH-1:0]   w_shift_in;
    logic                    r_frame_error;
    logic                    w_frame_error_n;
    logic                    w_done;

    assign w_shift_in = {data_in, r_shift[DATA_WIDTH-1:1]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_shift       <= '0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_count       <= w_count_n;
            r_shift       <= w_shift_n;
            r_frame_error <= w_frame_error_n;
        end
    end

    // Next-state logic; w_done marks the edge that captures the last bit of a word.
    always_comb begin
        w_state_n       = r_state;
        w_count_n       = r_count;
        w_shift_n       = r_shift;
        w_frame_error_n = 1'b0;
        w_done          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_in) begin
                    w_shift_n = w_shift_in;
                    w_count_n = COUNTER_SIZE'(1);
                    w_state_n = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (frame_in) begin
                    w_shift_n = w_shift_in;
                    if (r_count == COUNTER_SIZE'(DATA_WIDTH - 1)) begin
                        w_done    = 1'b1;
                        w_count_n = '0;
                        w_state_n = ST_IDLE;
                    end else begin
                        w_count_n = r_count + COUNTER_SIZE'(1);
                    end
                end else begin
                    // Truncated frame: drop the partial word.
                    w_shift_n       = '0;
                    w_count_n       = '0;
                    w_frame_error_n = 1'b1;
                    w_state_n       = ST_IDLE;
                end
            end
            default: begin
                w_count_n = '0;
                w_state_n = ST_IDLE;
            end
        endcase
    end

    deserializer_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_done),
        .i_word    (w_shift_in),
        .i_ready   (ready),
        .o_data    (data_out),
        .o_valid   (valid),
        .o_overrun (overrun)
    );

    assign frame_error = r_frame_error;

endmodule
